// File: rtl/ahb_csr_bridge.sv
// AHB-Lite slave that turns single word transfers into one-cycle CSR read/write strobes.
// Optional ERROR response for sub-word or misaligned accesses: define AHB_CSR_BRIDGE_ERR_EN.
module ahb_csr_bridge #(
    parameter int CSR_AW = 2
) (
    input  logic              clk_i,
    input  logic              rstb_i,
    input  logic              HSEL,
    input  logic [31:0]       HADDR,
    input  logic [1:0]        HTRANS,
    input  logic              HWRITE,
    input  logic [2:0]        HSIZE,
    input  logic [31:0]       HWDATA,
    input  logic              HREADY,
    output logic              HREADYOUT,
    output logic              HRESP,
    output logic [31:0]       HRDATA,
    output logic              re_o,
    output logic              we_o,
    output logic [CSR_AW-1:0] addr_o,
    output logic [31:0]       data_o,
    input  logic [31:0]       data_i
);

`ifdef AHB_CSR_BRIDGE_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RDOUT = 3'd3,
        ST_ERR1  = 3'd4,
        ST_ERR2  = 3'd5
    } state_t;

    function automatic logic size_err(input logic [2:0] size, input logic [1:0] lsb);
        return (size != 3'b010) || (lsb != 2'b00);
    endfunction
`else
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_RD    = 3'd2,
        ST_RDOUT = 3'd3
    } state_t;
`endif

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CSR_AW-1:0]   addr_r;
    logic [31:0]         rdata_r;
    logic                accept_s;
    logic                unused_s;

    assign accept_s = HSEL & HTRANS[1] & HREADY;

`ifdef AHB_CSR_BRIDGE_ERR_EN
    logic err_s;
    assign err_s    = size_err(HSIZE, HADDR[1:0]);
    assign unused_s = ^HADDR[31:CSR_AW+2];
`else
    // Size and byte lane are irrelevant when every access is treated as a full word.
    assign unused_s = ^{HSIZE, HADDR[31:CSR_AW+2], HADDR[1:0]};
`endif

    // State register.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Address-phase capture of the CSR word address.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            addr_r <= {CSR_AW{1'b0}};
        end else if (accept_s) begin
            addr_r <= HADDR[CSR_AW+1:2];
        end else begin
            addr_r <= addr_r;
        end
    end

    // Read data register so HRDATA never comes straight from the CSR mux.
    always_ff @(posedge clk_i or negedge rstb_i) begin
        if (!rstb_i) begin
            rdata_r <= 32'h0000_0000;
        end else if (state_r == ST_RD) begin
            rdata_r <= data_i;
        end else begin
            rdata_r <= rdata_r;
        end
    end

    // Next-state decode; every state that ends with HREADYOUT=1 may accept a new transfer.
    always_comb begin
        state_nxt_s = ST_IDLE;
        case (state_r)
            ST_RD: begin
                state_nxt_s = ST_RDOUT;
            end
`ifdef AHB_CSR_BRIDGE_ERR_EN
            ST_ERR1: begin
                state_nxt_s = ST_ERR2;
            end
`endif
            default: begin
                if (!accept_s) begin
                    state_nxt_s = ST_IDLE;
                end
`ifdef AHB_CSR_BRIDGE_ERR_EN
                else if (err_s) begin
                    state_nxt_s = ST_ERR1;
                end
`endif
                else if (HWRITE) begin
                    state_nxt_s = ST_WR;
                end else begin
                    state_nxt_s = ST_RD;
                end
            end
        endcase
    end

    // Per-state bus response and CSR strobes; address and data are zero outside a strobe.
    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = 1'b0;
        re_o      = 1'b0;
        we_o      = 1'b0;
        addr_o    = {CSR_AW{1'b0}};
        data_o    = 32'h0000_0000;
        case (state_r)
            ST_WR: begin
                we_o   = 1'b1;
                addr_o = addr_r;
                data_o = HWDATA;
            end
            ST_RD: begin
                re_o      = 1'b1;
                addr_o    = addr_r;
                HREADYOUT = 1'b0;
            end
`ifdef AHB_CSR_BRIDGE_ERR_EN
            ST_ERR1: begin
                HRESP     = 1'b1;
                HREADYOUT = 1'b0;
            end
            ST_ERR2: begin
                HRESP     = 1'b1;
            end
`endif
            default: begin
                HREADYOUT = 1'b1;
            end
        endcase
    end

    assign HRDATA = rdata_r;

endmodule

// File: tb/tb_ahb_csr_bridge.sv
// Self-checking bench for ahb_csr_bridge: directed vector table, pipelined sequences,
// mid-read reset and a randomized stream checked against a transaction-level model.
module tb_ahb_csr_bridge;
    localparam int CSR_AW = 2;

    logic              clk_i = 1'b0;
    logic              rstb_i;
    logic              HSEL;
    logic [31:0]       HADDR;
    logic [1:0]        HTRANS;
    logic              HWRITE;
    logic [2:0]        HSIZE;
    logic [31:0]       HWDATA;
    logic              HREADY;
    logic              HREADYOUT;
    logic              HRESP;
    logic [31:0]       HRDATA;
    logic              re_o;
    logic              we_o;
    logic [CSR_AW-1:0] addr_o;
    logic [31:0]       data_o;
    logic [31:0]       data_i;

    ahb_csr_bridge #(.CSR_AW(CSR_AW)) dut (
        .clk_i(clk_i), .rstb_i(rstb_i), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HSIZE(HSIZE), .HWDATA(HWDATA), .HREADY(HREADY),
        .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA), .re_o(re_o), .we_o(we_o),
        .addr_o(addr_o), .data_o(data_o), .data_i(data_i)
    );

    always #5 clk_i = ~clk_i;

    // Stand-in CSR block: four registers, combinational read, written on we_o.
    logic [31:0] csr [4];
    assign data_i = csr[addr_o];
    always @(posedge clk_i) if (we_o) csr[addr_o] <= data_o;
    assign HREADY = HREADYOUT;

    int n_cmp = 0;
    int n_bad = 0;
    logic [31:0] mem [4];

    typedef struct {
        bit          we, re, rdy, resp, chk_rd;
        logic [1:0]  addr;
        logic [31:0] data, rdata;
    } cyc_t;

    typedef struct {
        bit          sel;
        logic [1:0]  trans;
        bit          write;
        logic [31:0] haddr;
        logic [2:0]  size;
        logic [31:0] wdata;
    } ph_t;

    typedef struct {
        bit          write;
        logic [31:0] haddr;
        logic [2:0]  size;
        logic [31:0] wdata;
        bit          e_we, e_re, e_resp;
        logic [1:0]  e_addr;
        logic [31:0] e_data, e_rdata;
    } vec_t;

    cyc_t expq[$];
    ph_t  phq[$];
    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic bit is_err(input ph_t p);
`ifdef AHB_CSR_BRIDGE_ERR_EN
        return (p.size != 3'd2) || (p.haddr[1:0] != 2'd0);
`else
        return 1'b0;
`endif
    endfunction

    function automatic cyc_t idle_cyc();
        cyc_t c;
        c = '{default: '0};
        c.rdy = 1'b1;
        return c;
    endfunction

    // Transaction model: expected data-phase cycles of one accepted transfer.
    task automatic push_model(input ph_t p);
        cyc_t c;
        logic [1:0] a;
        a = p.haddr[3:2];
        c = '{default: '0};
        if (is_err(p)) begin
            c.resp = 1'b1;
            expq.push_back(c);
            c.rdy = 1'b1;
            expq.push_back(c);
        end else if (p.write) begin
            c.we = 1'b1; c.rdy = 1'b1; c.addr = a; c.data = p.wdata;
            mem[a] = p.wdata;
            expq.push_back(c);
        end else begin
            c.re = 1'b1; c.addr = a;
            expq.push_back(c);
            c = idle_cyc();
            c.chk_rd = 1'b1; c.rdata = mem[a];
            expq.push_back(c);
        end
    endtask

    task automatic check_cycle(input cyc_t e, input string tag);
        chk({tag, ".re_o"}, re_o, e.re);
        chk({tag, ".we_o"}, we_o, e.we);
        chk({tag, ".addr_o"}, addr_o, e.addr);
        chk({tag, ".data_o"}, data_o, e.data);
        chk({tag, ".HREADYOUT"}, HREADYOUT, e.rdy);
        chk({tag, ".HRESP"}, HRESP, e.resp);
        if (e.chk_rd) chk({tag, ".HRDATA"}, HRDATA, e.rdata);
    endtask

    task automatic drive(input ph_t p);
        HSEL = p.sel; HTRANS = p.trans; HWRITE = p.write; HADDR = p.haddr; HSIZE = p.size;
    endtask

    // Pipelined master: plays phq against the DUT and checks every cycle against the model.
    task automatic run_stream(input string tag);
        ph_t  cur, idle_ph;
        cyc_t e;
        bit   acc, rdy_prev, done;
        int   budget;
        idle_ph = '{sel: 1'b0, trans: 2'b00, write: 1'b0, haddr: 32'h0, size: 3'd2, wdata: 32'h0};
        cur = idle_ph; acc = 1'b0; rdy_prev = 1'b1; done = 1'b0;
        expq.delete();
        budget = 4 * phq.size() + 20;
        for (int cyc = 0; cyc < budget && !done; cyc++) begin
            @(posedge clk_i); #1;
            if (acc) push_model(cur);
            e = (expq.size() != 0) ? expq.pop_front() : idle_cyc();
            HWDATA = e.we ? e.data : $urandom();
            if (rdy_prev) begin
                cur = (phq.size() != 0) ? phq.pop_front() : idle_ph;
                drive(cur);
            end
            @(negedge clk_i);
            check_cycle(e, tag);
            rdy_prev = HREADYOUT;
            acc = cur.sel && cur.trans[1] && HREADYOUT;
            done = (phq.size() == 0) && (expq.size() == 0) && !acc && rdy_prev;
        end
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL %s.timeout: stream not drained within %0d cycles", tag, budget);
        end
        drive(idle_ph);
    endtask

    // One isolated transfer from the vector table, followed by an idle cycle.
    task automatic do_xfer(input vec_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        @(posedge clk_i); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = v.write; HADDR = v.haddr; HSIZE = v.size;
        HWDATA = $urandom();
        @(posedge clk_i); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        HWDATA = v.write ? v.wdata : $urandom();
        @(negedge clk_i);
        chk({tag, ".we_o"}, we_o, v.e_we);
        chk({tag, ".re_o"}, re_o, v.e_re);
        chk({tag, ".addr_o"}, addr_o, v.e_addr);
        chk({tag, ".data_o"}, data_o, v.e_data);
        chk({tag, ".HREADYOUT1"}, HREADYOUT, !(v.e_re || v.e_resp));
        chk({tag, ".HRESP1"}, HRESP, v.e_resp);
        if (v.e_re || v.e_resp) begin
            @(negedge clk_i);
            chk({tag, ".HREADYOUT2"}, HREADYOUT, 1'b1);
            chk({tag, ".HRESP2"}, HRESP, v.e_resp);
            chk({tag, ".strobe2"}, {re_o, we_o}, 2'b00);
            if (v.e_re) chk({tag, ".HRDATA"}, HRDATA, v.e_rdata);
        end
        @(negedge clk_i);
        chk({tag, ".HRESP_idle"}, HRESP, 1'b0);
        chk({tag, ".HREADYOUT_idle"}, HREADYOUT, 1'b1);
        if (v.e_we) mem[v.e_addr] = v.e_data;
    endtask

    function automatic ph_t mkph(input bit sel, input logic [1:0] tr, input bit wr,
                                 input logic [31:0] a, input logic [31:0] d);
        return '{sel: sel, trans: tr, write: wr, haddr: a, size: 3'd2, wdata: d};
    endfunction

    initial begin
        ph_t p;
        rstb_i = 1'b0; HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
        HADDR = 32'h0; HSIZE = 3'd2; HWDATA = 32'h0;
        #2;
        chk("rst.HREADYOUT", HREADYOUT, 1'b1);
        chk("rst.HRESP", HRESP, 1'b0);
        chk("rst.HRDATA", HRDATA, 32'h0);
        chk("rst.strobes", {re_o, we_o}, 2'b00);
        chk("rst.addr_o", addr_o, 2'd0);
        chk("rst.data_o", data_o, 32'h0);
        @(negedge clk_i); #2;
        rstb_i = 1'b1;

        vt.push_back('{1'b1, 32'h0, 3'd2, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0005, 32'h0});
        vt.push_back('{1'b1, 32'h8, 3'd2, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 2'd2, 32'h1234_5678, 32'h0});
        vt.push_back('{1'b0, 32'h8, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 2'd2, 32'h0, 32'h1234_5678});
        vt.push_back('{1'b1, 32'h4, 3'd2, 32'hA5A5_A5A5, 1'b1, 1'b0, 1'b0, 2'd1, 32'hA5A5_A5A5, 32'h0});
        vt.push_back('{1'b0, 32'h4, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 2'd1, 32'h0, 32'hA5A5_A5A5});
        vt.push_back('{1'b1, 32'hC, 3'd2, 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b0, 2'd3, 32'hDEAD_BEEF, 32'h0});
        vt.push_back('{1'b0, 32'hC, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 2'd3, 32'h0, 32'hDEAD_BEEF});
        vt.push_back('{1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_0005});
`ifdef AHB_CSR_BRIDGE_ERR_EN
        vt.push_back('{1'b1, 32'h1, 3'd0, 32'h0000_0077, 1'b0, 1'b0, 1'b1, 2'd0, 32'h0, 32'h0});
        vt.push_back('{1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_0005});
`else
        vt.push_back('{1'b1, 32'h1, 3'd0, 32'h0000_0077, 1'b1, 1'b0, 1'b0, 2'd0, 32'h0000_0077, 32'h0});
        vt.push_back('{1'b0, 32'h0, 3'd2, 32'h0, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0, 32'h0000_0077});
`endif
        for (int i = 0; i < vt.size(); i++) do_xfer(vt[i], i);

        // Streaming writes, then write followed immediately by a read of the same word.
        for (int i = 0; i < 4; i++) phq.push_back(mkph(1'b1, 2'b10, 1'b1, 32'(i * 4), 32'h1111_0000 + 32'(i)));
        phq.push_back(mkph(1'b1, 2'b11, 1'b1, 32'h4, 32'hA5A5_A5A5));
        phq.push_back(mkph(1'b1, 2'b10, 1'b0, 32'h4, 32'h0));
        phq.push_back(mkph(1'b1, 2'b10, 1'b0, 32'h8, 32'h0));
        run_stream("b2b");

        // IDLE and BUSY transfers with HSEL high do nothing.
        phq.push_back(mkph(1'b1, 2'b00, 1'b1, 32'h8, 32'hFFFF_FFFF));
        phq.push_back(mkph(1'b1, 2'b01, 1'b1, 32'h8, 32'hFFFF_FFFF));
        phq.push_back(mkph(1'b1, 2'b01, 1'b0, 32'h4, 32'h0));
        run_stream("idlebusy");

        // Reset during the read wait cycle drops the transfer immediately.
        @(posedge clk_i); #1;
        HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = 32'h8; HSIZE = 3'd2;
        @(posedge clk_i); #1;
        HSEL = 1'b0; HTRANS = 2'b00;
        @(negedge clk_i);
        chk("rdrst.re_before", re_o, 1'b1);
        chk("rdrst.ready_before", HREADYOUT, 1'b0);
        #1 rstb_i = 1'b0;
        #1;
        chk("rdrst.re_o", re_o, 1'b0);
        chk("rdrst.HREADYOUT", HREADYOUT, 1'b1);
        chk("rdrst.HRDATA", HRDATA, 32'h0);
        chk("rdrst.addr_o", addr_o, 2'd0);
        #1 rstb_i = 1'b1;
        phq.push_back(mkph(1'b1, 2'b10, 1'b0, 32'h8, 32'h0));
        run_stream("postrst");

        // Randomized stream.
        for (int i = 0; i < 300; i++) begin
            p.sel   = ($urandom_range(0, 9) != 0);
            p.trans = 2'($urandom_range(0, 3));
            p.write = 1'($urandom_range(0, 1));
            p.haddr = $urandom();
            if ($urandom_range(0, 4) != 0) p.haddr[1:0] = 2'b00;
            p.size  = ($urandom_range(0, 4) != 0) ? 3'd2 : 3'($urandom_range(0, 7));
            p.wdata = $urandom();
            phq.push_back(p);
        end
        run_stream("rand");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
